// File: rtl/cdc_pulse_src_pkg.sv
// Shared constants for the clock-domain-crossing helpers.
// A synchroniser needs at least SYNC_MIN flops.
package cdc_pulse_src_pkg;
   localparam int SYNC_MIN = 2;
endpackage

// File: rtl/sync_n.sv
// N-stage level synchroniser for a slow-changing async input.
// Latency is N clock cycles. There is no backpressure; the input is sampled every cycle.
module sync_n
   import cdc_pulse_src_pkg::*;
#(
   parameter int N = SYNC_MIN
) (
   input  logic c,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic [N-1:0] r_sync;

   generate
      if (N < SYNC_MIN) begin : g_bad_depth
         $error("sync_n: N below SYNC_MIN");
      end
   endgenerate

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[N-2:0], i_d};
      end
   end

   assign o_q = r_sync[N-1];

endmodule

// File: rtl/cdc_pulse_src.sv
// Source half of a toggle CDC handshake: launches a word by flipping o_tgl, holds o_data until acked.
// Launch latency is 1 cycle. A one-word skid queues behind the in-flight word; a full skid drops input (o_drop).
module cdc_pulse_src
   import cdc_pulse_src_pkg::*;
#(
   parameter int DW       = 8,
   parameter int ACK_SYNC = 2
) (
   input  logic          c,
   input  logic          rst,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          o_ready,
   output logic          o_drop,
   output logic          o_tgl,
   output logic [DW-1:0] o_data,
   input  logic          i_ack_tgl,
   output logic          o_busy,
   output logic          o_done
);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_tgl;
   logic          w_tgl_nxt;
   logic [DW-1:0] r_data;
   logic [DW-1:0] w_data_nxt;
   logic [DW-1:0] r_skid;
   logic [DW-1:0] w_skid_nxt;
   logic          r_skid_full;
   logic          w_skid_full_nxt;
   logic          w_ack_s;
   logic          w_ack_seen;

   generate
      if (ACK_SYNC < SYNC_MIN) begin : g_bad_ack_sync
         $error("cdc_pulse_src: ACK_SYNC below SYNC_MIN");
      end
   endgenerate

   sync_n #(
      .N (ACK_SYNC)
   ) u_ack_sync (
      .c   (c),
      .rst (rst),
      .i_d (i_ack_tgl),
      .o_q (w_ack_s)
   );

   // The returned toggle matching our own level means the destination has taken the word.
   assign w_ack_seen = (r_state == WAIT_ACK) && (w_ack_s == r_tgl);

   always_comb begin
      w_state_nxt     = r_state;
      w_tgl_nxt       = r_tgl;
      w_data_nxt      = r_data;
      w_skid_nxt      = r_skid;
      w_skid_full_nxt = r_skid_full;
      case (r_state)
         IDLE: begin
            if (i_valid) begin
               w_data_nxt  = i_data;
               w_tgl_nxt   = ~r_tgl;
               w_state_nxt = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (!w_ack_seen) begin
               if (i_valid && !r_skid_full) begin
                  w_skid_nxt      = i_data;
                  w_skid_full_nxt = 1'b1;
               end
            end else if (r_skid_full) begin
               w_data_nxt      = r_skid;
               w_tgl_nxt       = ~r_tgl;
               w_skid_full_nxt = 1'b0;
            end else if (i_valid) begin
               w_data_nxt = i_data;
               w_tgl_nxt  = ~r_tgl;
            end else begin
               w_state_nxt = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_tgl       <= 1'b0;
         r_data      <= '0;
         r_skid      <= '0;
         r_skid_full <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_tgl       <= w_tgl_nxt;
         r_data      <= w_data_nxt;
         r_skid      <= w_skid_nxt;
         r_skid_full <= w_skid_full_nxt;
      end
   end

   assign o_ready = ~r_skid_full;
   assign o_drop  = i_valid & r_skid_full;
   assign o_busy  = (r_state == WAIT_ACK);
   assign o_done  = w_ack_seen;
   assign o_tgl   = r_tgl;
   assign o_data  = r_data;

endmodule
